iir6_seq_engine: RTL

Sixth-order Direct Form II Transposed IIR engine that time-multiplexes one 18x18 signed multiplier across all 13 coefficient products per audio sample. It runs on the fast state clock and is triggered once per sample by a one-cycle strobe derived from the LR clock. It owns a double-buffered coefficient bank that is written through a narrow register port and swapped atomically at a sample boundary. It is the sequenced, area-reduced counterpart of the fully parallel IIR6 filter and uses the same 2.16 arithmetic.

---
 rtl/iir6_seq_engine.sv | 134 +++++++++++++
 1 files changed

// File: rtl/iir6_seq_engine.sv
// Sixth-order DF-II-T IIR engine (2.16 arithmetic) sharing one 18x18 multiplier over
// 13 products per sample. i_reset is asynchronous and active-low.
module iir6_seq_engine (
  input  logic        i_state_clk,
  input  logic        i_reset,
  input  logic        i_sample_strobe,
  input  logic [15:0] i_audio_in,
  input  logic [2:0]  i_scale,
  input  logic        i_coef_wr,
  input  logic [3:0]  i_coef_addr,
  input  logic [17:0] i_coef_data,
  input  logic        i_coef_commit,
  output logic [15:0] o_audio_out,
  output logic        o_out_valid,
  output logic        o_busy,
  output logic        o_overrun
);

  typedef enum logic [3:0] {
    S_IDLE, S_B1, S_B2, S_A2, S_B3, S_A3, S_B4, S_A4,
    S_B5, S_A5, S_B6, S_A6, S_B7, S_A7
  } state_t;

  state_t             r_state, w_nextState;
  logic signed [17:0] r_x, r_y, r_acc;
  logic [2:0]         r_scale;
  logic signed [17:0] r_s      [0:5];
  logic signed [17:0] r_shadow [0:12];
  logic signed [17:0] r_active [0:12];
  logic               r_pending, r_outValid, r_overrun;
  logic [15:0]        r_audioOut;

  logic               w_busy, w_accept, w_useY;
  logic [3:0]         w_coefIdx;
  logic [2:0]         w_sIdx;
  logic signed [17:0] w_sNext, w_coef, w_data, w_mult, w_ySum, w_yScaled;
  logic signed [35:0] w_prod;
  logic               w_unusedProd;

  assign w_busy   = (r_state != S_IDLE);
  assign w_accept = i_sample_strobe && !w_busy;

  always_ff @(posedge i_state_clk or negedge i_reset) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (i_sample_strobe) w_nextState = S_B1;
      S_A7:    w_nextState = S_IDLE;
      default: w_nextState = state_t'(r_state + 4'd1);
    endcase
  end

  // Operand selection and state-slot routing depend on the state alone
  always_comb begin
    w_coefIdx = 4'd0;
    w_useY    = 1'b0;
    w_sIdx    = 3'd0;
    w_sNext   = '0;
    case (r_state)
      S_B2: w_coefIdx = 4'd1;
      S_B3: w_coefIdx = 4'd2;
      S_B4: w_coefIdx = 4'd3;
      S_B5: w_coefIdx = 4'd4;
      S_B6: w_coefIdx = 4'd5;
      S_B7: w_coefIdx = 4'd6;
      S_A2: begin w_coefIdx = 4'd7;  w_useY = 1'b1; w_sIdx = 3'd0; w_sNext = r_s[1]; end
      S_A3: begin w_coefIdx = 4'd8;  w_useY = 1'b1; w_sIdx = 3'd1; w_sNext = r_s[2]; end
      S_A4: begin w_coefIdx = 4'd9;  w_useY = 1'b1; w_sIdx = 3'd2; w_sNext = r_s[3]; end
      S_A5: begin w_coefIdx = 4'd10; w_useY = 1'b1; w_sIdx = 3'd3; w_sNext = r_s[4]; end
      S_A6: begin w_coefIdx = 4'd11; w_useY = 1'b1; w_sIdx = 3'd4; w_sNext = r_s[5]; end
      S_A7: begin w_coefIdx = 4'd12; w_useY = 1'b1; w_sIdx = 3'd5; end
      default: ;
    endcase
  end

  assign w_coef       = r_active[w_coefIdx];
  assign w_data       = w_useY ? r_y : r_x;
  assign w_prod       = w_coef * w_data;
  assign w_mult       = {w_prod[35], w_prod[32:16]};
  assign w_ySum       = r_s[0] + w_mult;
  assign w_yScaled    = w_ySum << r_scale;
  assign w_unusedProd = ^{w_prod[34:33], w_prod[15:0]};

  // Bank swap reads pre-edge shadow, so a same-edge write lands only in shadow
  always_ff @(posedge i_state_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_x        <= '0;
      r_y        <= '0;
      r_acc      <= '0;
      r_scale    <= '0;
      r_pending  <= 1'b0;
      r_outValid <= 1'b0;
      r_overrun  <= 1'b0;
      r_audioOut <= '0;
      for (int i = 0; i < 6; i++)  r_s[i] <= '0;
      for (int i = 0; i < 13; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      r_outValid <= 1'b0;
      if (i_coef_wr && (i_coef_addr <= 4'd12)) r_shadow[i_coef_addr] <= i_coef_data;
      if (w_accept) begin
        r_x     <= {i_audio_in, 2'b00};
        r_scale <= i_scale;
        if (r_pending || i_coef_commit)
          for (int i = 0; i < 13; i++) r_active[i] <= r_shadow[i];
        r_pending <= 1'b0;
      end else if (i_coef_commit) begin
        r_pending <= 1'b1;
      end
      if (i_sample_strobe && w_busy) r_overrun <= 1'b1;
      if (r_state == S_B1) begin
        r_y        <= w_yScaled;
        r_audioOut <= w_yScaled[17:2];
        r_outValid <= 1'b1;
      end else if (w_useY) begin
        r_s[w_sIdx] <= r_acc + w_sNext + w_mult;
      end else if (w_busy) begin
        r_acc <= w_mult;
      end
    end
  end

  assign o_audio_out = r_audioOut;
  assign o_out_valid = r_outValid;
  assign o_busy      = w_busy;
  assign o_overrun   = r_overrun;

endmodule
